// File: rtl/dec_msg_compress_if.sv
// rtl/dec_msg_compress_if.sv - M3 read port and message output bundle for dec_msg_compress
//
// Purpose: groups the slice request, the M3 read port and the message outputs.
// Signals:
//   start      slice request (one cycle)
//   M3_RAd     M3 read address
//   M3_RData   M3 read data, 8 lanes of signed 16-bit coefficients
//   busy       slice in progress
//   msg_valid  msg_byte/msg_idx valid this cycle
//   msg_idx    word index of msg_byte
//   msg_byte   compressed bits of one word, bit i from lane i
//   msg_slice  accumulated 64-bit message slice
//   done       one-cycle completion pulse
// Modports: slave = compressor side, master = controller/memory side.
interface dec_msg_compress_if;
  logic         start;
  logic [2:0]   M3_RAd;
  logic [127:0] M3_RData;
  logic         busy;
  logic         msg_valid;
  logic [2:0]   msg_idx;
  logic [7:0]   msg_byte;
  logic [63:0]  msg_slice;
  logic         done;

  modport slave (
    input  start, M3_RData,
    output M3_RAd, busy, msg_valid, msg_idx, msg_byte, msg_slice, done
  );

  modport master (
    output start, M3_RData,
    input  M3_RAd, busy, msg_valid, msg_idx, msg_byte, msg_slice, done
  );
endinterface

// File: rtl/dec_msg_compress.sv
// rtl/dec_msg_compress.sv - M3 slice reduce mod q and 1-bit compress into message bytes
//
// Purpose: on start, reads NWORDS words from M3, reduces every signed 16-bit
// lane mod Q (Barrett), compresses each residue to one message bit and emits
// one packed byte per word plus the accumulated 64-bit slice.
// Ports:
//   clk    system clock
//   rst_n  synchronous active-low reset
//   bus    dec_msg_compress_if.slave (start, M3 read port, message outputs)
// Parameters: NWORDS (words per slice, power of 2, <= 8), RD_LAT (1 or 2), Q.
// Build option: DEC_MSG_BARRETT_PIPE_EN adds a register between the Barrett
// multiply and the subtract/correct step (one extra cycle of latency).
module dec_msg_compress #(
  parameter int NWORDS = 8,
  parameter int RD_LAT = 1,
  parameter int Q      = 3329
) (
  input logic               clk,
  input logic               rst_n,
  dec_msg_compress_if.slave bus
);

  localparam int CW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CW-1:0]     LAST_CNT = CW'(NWORDS - 1);
  localparam logic [2:0]        LAST_IDX = 3'(NWORDS - 1);
  localparam logic signed [31:0] BARRETT_V = 32'sd20159;
  localparam logic signed [17:0] QS = 18'(Q);
  // bit = round(2r/Q) mod 2, i.e. Q/4 < r < 3Q/4
  localparam logic signed [17:0] LO = 18'(Q / 4 + 1);
  localparam logic signed [17:0] HI = 18'((3 * Q) / 4);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t        stateQ, stateD;
  logic [CW-1:0] cnt;
  logic          accept;

  // floor(x * v / 2^26); may be one off from floor(x / Q), fixed in msgBit
  function automatic logic signed [5:0] barrettQuot(input logic signed [15:0] x);
    logic signed [31:0] p;
    p = 32'(x) * BARRETT_V;
    return p[31:26];
  endfunction

  function automatic logic msgBit(input logic signed [15:0] x, input logic signed [5:0] t);
    logic signed [17:0] r;
    r = 18'(x) - 18'(t) * QS;
    if (r < 18'sd0) begin
      r = r + QS;
    end else if (r >= QS) begin
      r = r - QS;
    end
    return (r >= LO) && (r <= HI);
  endfunction

  assign accept = (stateQ == IDLE) && bus.start;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateQ <= IDLE;
    end else begin
      stateQ <= stateD;
    end
  end

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      IDLE:    if (bus.start) stateD = READ;
      READ:    if (cnt == LAST_CNT) stateD = DRAIN;
      DRAIN:   if (bus.msg_valid && (bus.msg_idx == LAST_IDX)) stateD = DONE;
      DONE:    stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if (stateQ == READ) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign bus.busy   = (stateQ != IDLE);
  assign bus.done   = (stateQ == DONE);
  assign bus.M3_RAd = (stateQ == READ) ? 3'(cnt) : 3'd0;

  // Tag each issued address so its data is captured exactly RD_LAT cycles later
  logic [RD_LAT-1:0]      latVld;
  logic [RD_LAT-1:0][2:0] latIdx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      latVld <= '0;
      latIdx <= '0;
    end else begin
      latVld[0] <= (stateQ == READ);
      latIdx[0] <= 3'(cnt);
      for (int i = 1; i < RD_LAT; i++) begin
        latVld[i] <= latVld[i-1];
        latIdx[i] <= latIdx[i-1];
      end
    end
  end

  logic         capVld;
  logic [2:0]   capIdx;
  logic [127:0] capData;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      capVld  <= 1'b0;
      capIdx  <= '0;
      capData <= '0;
    end else begin
      capVld <= latVld[RD_LAT-1];
      if (latVld[RD_LAT-1]) begin
        capIdx  <= latIdx[RD_LAT-1];
        capData <= bus.M3_RData;
      end
    end
  end

  logic       srcVld;
  logic [2:0] srcIdx;
  logic [7:0] packBits;

`ifdef DEC_MSG_BARRETT_PIPE_EN
  logic                  mulVld;
  logic [2:0]            mulIdx;
  logic [7:0][15:0]      mulX;
  logic [7:0][5:0]       mulT;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mulVld <= 1'b0;
      mulIdx <= '0;
      mulX   <= '0;
      mulT   <= '0;
    end else begin
      mulVld <= capVld;
      if (capVld) begin
        mulIdx <= capIdx;
        for (int i = 0; i < 8; i++) begin
          mulX[i] <= capData[16*i +: 16];
          mulT[i] <= barrettQuot(capData[16*i +: 16]);
        end
      end
    end
  end

  always_comb begin
    srcVld   = mulVld;
    srcIdx   = mulIdx;
    packBits = '0;
    for (int i = 0; i < 8; i++) begin
      packBits[i] = msgBit(mulX[i], mulT[i]);
    end
  end
`else
  always_comb begin
    srcVld   = capVld;
    srcIdx   = capIdx;
    packBits = '0;
    for (int i = 0; i < 8; i++) begin
      packBits[i] = msgBit(capData[16*i +: 16], barrettQuot(capData[16*i +: 16]));
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.msg_valid <= 1'b0;
      bus.msg_idx   <= '0;
      bus.msg_byte  <= '0;
      bus.msg_slice <= '0;
    end else begin
      bus.msg_valid <= srcVld;
      if (srcVld) begin
        bus.msg_idx  <= srcIdx;
        bus.msg_byte <= packBits;
      end
      // Pipeline is empty whenever a start is accepted, so clear never races an update
      if (accept) begin
        bus.msg_slice <= '0;
      end else if (srcVld) begin
        bus.msg_slice[8*srcIdx +: 8] <= packBits;
      end
    end
  end

endmodule
